// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types and constants for the ID-stage hazard controller.
package pipeline_hazard_controller_pkg;

  localparam int unsigned REG_W         = 5;
  localparam int unsigned CNT_W_DEFAULT = 16;
  localparam logic [REG_W-1:0] XZR      = 5'd31;

  typedef struct packed {
    logic             valid;
    logic             reg_write;
    logic             mem_read;
    logic [REG_W-1:0] rd;
  } sb_entry_t;

  localparam sb_entry_t SB_BUBBLE = '0;

  // A slot forwards a hazard on r only if it will really write r; XZR writes are discarded.
  function automatic logic sb_match(input logic             valid,
                                    input logic             reg_write,
                                    input logic [REG_W-1:0] rd,
                                    input logic [REG_W-1:0] r);
    return valid && reg_write && (rd == r) && (r != XZR);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-slot EX/MEM/WB shadow of the pipeline destination registers.
module hazard_scoreboard
  import pipeline_hazard_controller_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  input  logic      bubble,
  input  sb_entry_t id_entry,
  output sb_entry_t ex_slot,
  output sb_entry_t mem_slot,
  output sb_entry_t wb_slot
);

  always_ff @(posedge clock) begin
    if (reset) begin
      ex_slot  <= SB_BUBBLE;
      mem_slot <= SB_BUBBLE;
      wb_slot  <= SB_BUBBLE;
    end else begin
      wb_slot  <= mem_slot;
      mem_slot <= ex_slot;
      ex_slot  <= bubble ? SB_BUBBLE : id_entry;
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// ID-stage hazard detection: load-use and CBZ/CBNZ operand stalls, branch flush,
// stall-run watchdog and saturating performance counters.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter bit          WB_BYPASS = 1'b1,
  parameter int unsigned CNT_W     = CNT_W_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] read_register1,
  input  logic [REG_W-1:0] read_register2,
  input  logic             uses_rs2,
  input  logic             CB_instr,
  input  logic             RegWrite_id,
  input  logic             MemRead_id,
  input  logic [REG_W-1:0] write_register_id,
  input  logic             branch_taken,
  output logic             stall,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             IF_ID_Flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic             hazard_error
);

  localparam logic [1:0] RUN_LIMIT = 2'd3;

  sb_entry_t  id_entry;
  sb_entry_t  ex_slot;
  sb_entry_t  mem_slot;
  sb_entry_t  wb_slot;
  logic       ex_rs1;
  logic       ex_rs2;
  logic       mem_rs1;
  logic       wb_rs1;
  logic       load_use;
  logic       cb_hazard;
  logic [1:0] run_len;
  logic       unused_mem_read;

  // Only the EX slot's MemRead matters; older loads have already returned data.
  assign unused_mem_read = mem_slot.mem_read ^ wb_slot.mem_read;

  hazard_scoreboard u_scoreboard (
    .clock    (clock),
    .reset    (reset),
    .bubble   (stall),
    .id_entry (id_entry),
    .ex_slot  (ex_slot),
    .mem_slot (mem_slot),
    .wb_slot  (wb_slot)
  );

  always_comb begin
    id_entry           = SB_BUBBLE;
    id_entry.valid     = id_valid;
    id_entry.reg_write = RegWrite_id;
    id_entry.mem_read  = MemRead_id;
    id_entry.rd        = write_register_id;

    ex_rs1  = sb_match(ex_slot.valid, ex_slot.reg_write, ex_slot.rd, read_register1);
    ex_rs2  = sb_match(ex_slot.valid, ex_slot.reg_write, ex_slot.rd, read_register2);
    mem_rs1 = sb_match(mem_slot.valid, mem_slot.reg_write, mem_slot.rd, read_register1);
    wb_rs1  = sb_match(wb_slot.valid, wb_slot.reg_write, wb_slot.rd, read_register1);

    load_use = ex_slot.mem_read && (ex_rs1 || (uses_rs2 && ex_rs2));
    // CB compares in ID, so it needs the value before the normal EX forwarding path exists.
    cb_hazard = CB_instr && (ex_rs1 || mem_rs1 || (!WB_BYPASS && wb_rs1));

    stall       = !reset && id_valid && (load_use || cb_hazard);
    PC_write    = !stall;
    IF_ID_write = !stall;
    IF_ID_Flush = !reset && branch_taken && id_valid && !stall;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      run_len      <= '0;
      hazard_error <= 1'b0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!stall) begin
        run_len <= '0;
      end else if (run_len != RUN_LIMIT) begin
        run_len <= run_len + 2'd1;
      end
      if (stall && (run_len == RUN_LIMIT)) begin
        hazard_error <= 1'b1;
      end
      if (stall && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      if (IF_ID_Flush && (flush_count != '1)) begin
        flush_count <= flush_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench: bypass and non-bypass instances driven in lockstep against a history-queue model.
module tb_pipeline_hazard_controller;
  import pipeline_hazard_controller_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] read_register1 = '0;
  logic [4:0] read_register2 = '0;
  logic       uses_rs2 = 1'b0;
  logic       CB_instr = 1'b0;
  logic       RegWrite_id = 1'b0;
  logic       MemRead_id = 1'b0;
  logic [4:0] write_register_id = '0;
  logic       branch_taken = 1'b0;

  logic        stall_o    [2];
  logic        pcw_o      [2];
  logic        ifw_o      [2];
  logic        flush_o    [2];
  logic [15:0] sc_o       [2];
  logic [15:0] fc_o       [2];
  logic        err_o      [2];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  pipeline_hazard_controller #(.WB_BYPASS(1'b1), .CNT_W(16)) dut1 (
    .clock(clock), .reset(reset), .id_valid(id_valid),
    .read_register1(read_register1), .read_register2(read_register2),
    .uses_rs2(uses_rs2), .CB_instr(CB_instr), .RegWrite_id(RegWrite_id),
    .MemRead_id(MemRead_id), .write_register_id(write_register_id),
    .branch_taken(branch_taken), .stall(stall_o[1]), .PC_write(pcw_o[1]),
    .IF_ID_write(ifw_o[1]), .IF_ID_Flush(flush_o[1]), .stall_cycles(sc_o[1]),
    .flush_count(fc_o[1]), .hazard_error(err_o[1])
  );

  pipeline_hazard_controller #(.WB_BYPASS(1'b0), .CNT_W(16)) dut0 (
    .clock(clock), .reset(reset), .id_valid(id_valid),
    .read_register1(read_register1), .read_register2(read_register2),
    .uses_rs2(uses_rs2), .CB_instr(CB_instr), .RegWrite_id(RegWrite_id),
    .MemRead_id(MemRead_id), .write_register_id(write_register_id),
    .branch_taken(branch_taken), .stall(stall_o[0]), .PC_write(pcw_o[0]),
    .IF_ID_write(ifw_o[0]), .IF_ID_Flush(flush_o[0]), .stall_cycles(sc_o[0]),
    .flush_count(fc_o[0]), .hazard_error(err_o[0])
  );

  // Model: newest-first list of the last three issued instructions per instance.
  typedef struct {
    bit valid;
    bit rw;
    bit mr;
    int rd;
  } rec_t;

  rec_t hist1[$];
  rec_t hist0[$];
  int   run  [2] = '{0, 0};
  bit   err  [2] = '{0, 0};
  int   sc   [2] = '{0, 0};
  int   fc   [2] = '{0, 0};
  bit   e_stall [2];
  bit   e_flush [2];

  // A producer issued d+1 cycles ago: loads need d>=1; CB needs d>=2 with bypass, d>=3 without.
  function automatic bit exp_stall(input rec_t h[$], input bit bypass);
    bit hit = 1'b0;
    int reach = bypass ? 2 : 3;
    if (reset || !id_valid) return 1'b0;
    for (int d = 0; d < h.size(); d++) begin
      if (h[d].valid && h[d].rw && h[d].rd != 31) begin
        if (d == 0 && h[d].mr &&
            (h[d].rd == int'(read_register1) || (uses_rs2 && h[d].rd == int'(read_register2))))
          hit = 1'b1;
        if (CB_instr && d < reach && h[d].rd == int'(read_register1))
          hit = 1'b1;
      end
    end
    return hit;
  endfunction

  task automatic model_eval();
    e_stall[1] = exp_stall(hist1, 1'b1);
    e_stall[0] = exp_stall(hist0, 1'b0);
    for (int b = 0; b < 2; b++)
      e_flush[b] = !reset && id_valid && branch_taken && !e_stall[b];
  endtask

  task automatic model_advance();
    rec_t r;
    for (int b = 0; b < 2; b++) begin
      if (reset) begin
        run[b] = 0; err[b] = 1'b0; sc[b] = 0; fc[b] = 0;
      end else begin
        if (e_stall[b]) begin
          if (run[b] >= 3) err[b] = 1'b1;
          run[b]++;
          if (sc[b] < 65535) sc[b]++;
        end else begin
          run[b] = 0;
        end
        if (e_flush[b] && fc[b] < 65535) fc[b]++;
      end
      r.valid = !reset && !e_stall[b] && id_valid;
      r.rw    = RegWrite_id;
      r.mr    = MemRead_id;
      r.rd    = int'(write_register_id);
      if (b == 1) begin
        if (reset) hist1.delete(); else begin
          hist1.push_front(r);
          if (hist1.size() > 3) void'(hist1.pop_back());
        end
      end else begin
        if (reset) hist0.delete(); else begin
          hist0.push_front(r);
          if (hist0.size() > 3) void'(hist0.pop_back());
        end
      end
    end
  endtask

  task automatic tick();
    model_eval();
    @(posedge clock);
    model_advance();
    #1;
  endtask

  task automatic drive(input bit v, input int rs1, input int rs2, input bit u2, input bit cb,
                       input bit rw, input bit mr, input int rd, input bit br);
    id_valid = v; read_register1 = 5'(rs1); read_register2 = 5'(rs2); uses_rs2 = u2;
    CB_instr = cb; RegWrite_id = rw; MemRead_id = mr; write_register_id = 5'(rd);
    branch_taken = br;
  endtask

  task automatic drain();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1, 7, 8, 1, 1, 1, 1, 7, 1);
    #2;
    for (int b = 0; b < 2; b++) begin
      checks++;
      if (stall_o[b] !== 1'b0 || flush_o[b] !== 1'b0 || pcw_o[b] !== 1'b1 || ifw_o[b] !== 1'b1) begin
        errors++;
        $display("FAIL reset_comb[%0d]: stall=%b flush=%b pcw=%b ifw=%b, required 0 0 1 1",
                 b, stall_o[b], flush_o[b], pcw_o[b], ifw_o[b]);
      end
    end
    tick();
    tick();
    for (int b = 0; b < 2; b++) begin
      checks++;
      if (sc_o[b] !== 16'd0 || fc_o[b] !== 16'd0 || err_o[b] !== 1'b0) begin
        errors++;
        $display("FAIL reset_regs[%0d]: sc=%0h fc=%0h err=%b, required 0 0 0",
                 b, sc_o[b], fc_o[b], err_o[b]);
      end
    end
    reset = 1'b0;
    drain();
  endtask

  task automatic test_load_use();
    drive(1, 1, 0, 0, 0, 1, 1, 2, 0);          // LDUR X2
    tick();
    drive(1, 2, 4, 1, 0, 1, 0, 3, 0);          // ADD X3,X2,X4
    for (int c = 0; c < 3; c++) begin
      #2;
      for (int b = 0; b < 2; b++) begin
        checks++;
        if (stall_o[b] !== (c == 0) || pcw_o[b] !== (c != 0)) begin
          errors++;
          $display("FAIL load_use[%0d] cycle %0d: stall=%b pcw=%b, required %b %b",
                   b, c, stall_o[b], pcw_o[b], c == 0, c != 0);
        end
      end
      tick();
      if (c == 0) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    end
    for (int b = 0; b < 2; b++) begin
      checks++;
      if (sc_o[b] !== 16'd1) begin
        errors++;
        $display("FAIL load_use_count[%0d]: got %0d required 1", b, sc_o[b]);
      end
    end
    drain();
  endtask

  task automatic test_cb_run();
    int n [2] = '{0, 0};
    drive(1, 1, 0, 0, 0, 1, 0, 5, 0);          // ADD X5
    tick();
    drive(1, 5, 0, 0, 1, 0, 0, 0, 0);          // CBZ X5, held in ID
    for (int c = 0; c < 6; c++) begin
      #2;
      for (int b = 0; b < 2; b++) if (stall_o[b] === 1'b1) n[b]++;
      tick();
    end
    for (int b = 0; b < 2; b++) begin
      checks++;
      if (n[b] != (b == 1 ? 2 : 3) || err_o[b] !== 1'b0) begin
        errors++;
        $display("FAIL cb_run[%0d]: stall cycles=%0d err=%b, required %0d 0",
                 b, n[b], err_o[b], b == 1 ? 2 : 3);
      end
    end
    drain();
  endtask

  task automatic test_xzr();
    drive(1, 1, 0, 0, 0, 1, 1, 31, 0);         // LDUR X31
    tick();
    drive(1, 31, 31, 1, 1, 1, 0, 3, 0);        // reads X31 as both sources and as CB operand
    for (int c = 0; c < 3; c++) begin
      #2;
      for (int b = 0; b < 2; b++) begin
        checks++;
        if (stall_o[b] !== 1'b0) begin
          errors++;
          $display("FAIL xzr[%0d] cycle %0d: stall=%b required 0", b, c, stall_o[b]);
        end
      end
      tick();
    end
    drain();
  endtask

  task automatic test_flush();
    int base [2];
    for (int b = 0; b < 2; b++) base[b] = int'(fc_o[b]);
    drive(1, 1, 2, 0, 0, 0, 0, 0, 1);          // taken B
    #2;
    for (int b = 0; b < 2; b++) begin
      checks++;
      if (flush_o[b] !== 1'b1) begin
        errors++;
        $display("FAIL flush_b[%0d]: got %b required 1", b, flush_o[b]);
      end
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    for (int b = 0; b < 2; b++) begin
      checks++;
      if (flush_o[b] !== 1'b0 || int'(fc_o[b]) != base[b] + 1) begin
        errors++;
        $display("FAIL flush_count[%0d]: flush=%b count=%0d, required 0 %0d",
                 b, flush_o[b], fc_o[b], base[b] + 1);
      end
    end
    drain();
    drive(1, 1, 0, 0, 0, 1, 0, 6, 0);          // ADD X6
    tick();
    drive(1, 6, 0, 0, 1, 0, 0, 0, 1);          // taken CBZ X6
    for (int c = 0; c < 4; c++) begin
      #2;
      for (int b = 0; b < 2; b++) begin
        bit st = (c < (b == 1 ? 2 : 3));
        checks++;
        if (stall_o[b] !== st || flush_o[b] !== !st) begin
          errors++;
          $display("FAIL cb_flush[%0d] cycle %0d: stall=%b flush=%b, required %b %b",
                   b, c, stall_o[b], flush_o[b], st, !st);
        end
      end
      tick();
    end
    drain();
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      int p1 = $urandom_range(0, 6);
      int p2 = $urandom_range(0, 6);
      int pd = $urandom_range(0, 6);
      drive($urandom_range(0, 9) < 8, p1 == 6 ? 31 : p1, p2 == 6 ? 31 : p2,
            1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            pd == 6 ? 31 : pd, $urandom_range(0, 4) == 0);
      #2;
      model_eval();
      for (int b = 0; b < 2; b++) begin
        checks++;
        if (stall_o[b] !== e_stall[b] || pcw_o[b] !== !e_stall[b] || ifw_o[b] !== !e_stall[b] ||
            flush_o[b] !== e_flush[b]) begin
          errors++;
          $display("FAIL rand_comb[%0d] cycle %0d: stall=%b pcw=%b ifw=%b flush=%b, required %b %b %b %b",
                   b, c, stall_o[b], pcw_o[b], ifw_o[b], flush_o[b],
                   e_stall[b], !e_stall[b], !e_stall[b], e_flush[b]);
        end
        checks++;
        if (sc_o[b] !== 16'(sc[b]) || fc_o[b] !== 16'(fc[b]) || err_o[b] !== err[b]) begin
          errors++;
          $display("FAIL rand_regs[%0d] cycle %0d: sc=%0d fc=%0d err=%b, required %0d %0d %b",
                   b, c, sc_o[b], fc_o[b], err_o[b], sc[b], fc[b], err[b]);
        end
      end
      tick();
    end
    drain();
  endtask

  // EX slot is pinned to a producer of X5 so a held CBZ X5 can never resolve.
  task automatic test_watchdog_and_saturation();
    sb_entry_t frz;
    int guard = 0;
    frz = '{valid: 1'b1, reg_write: 1'b1, mem_read: 1'b1, rd: 5'd5};
    force dut1.ex_slot = frz;
    force dut0.ex_slot = frz;
    drive(1, 5, 5, 1, 1, 0, 0, 0, 0);
    for (int c = 1; c <= 5; c++) begin
      tick();
      for (int b = 0; b < 2; b++) begin
        checks++;
        if (stall_o[b] !== 1'b1 || err_o[b] !== (c >= 4)) begin
          errors++;
          $display("FAIL watchdog[%0d] after cycle %0d: stall=%b err=%b, required 1 %b",
                   b, c, stall_o[b], err_o[b], c >= 4);
        end
      end
    end
    while (sc_o[1] !== 16'hFFFF && guard < 70000) begin
      tick();
      guard++;
    end
    repeat (3) tick();
    for (int b = 0; b < 2; b++) begin
      checks++;
      if (sc_o[b] !== 16'hFFFF || err_o[b] !== 1'b1) begin
        errors++;
        $display("FAIL saturate[%0d]: sc=%0h err=%b, required ffff 1", b, sc_o[b], err_o[b]);
      end
    end
    reset = 1'b1;
    release dut1.ex_slot;
    release dut0.ex_slot;
    #2;
    for (int b = 0; b < 2; b++) begin
      checks++;
      if (stall_o[b] !== 1'b0 || pcw_o[b] !== 1'b1) begin
        errors++;
        $display("FAIL reset_mid_stall[%0d]: stall=%b pcw=%b, required 0 1", b, stall_o[b], pcw_o[b]);
      end
    end
    tick();
    reset = 1'b0;
    #2;
    for (int b = 0; b < 2; b++) begin
      checks++;
      if (stall_o[b] !== 1'b0 || sc_o[b] !== 16'd0 || fc_o[b] !== 16'd0 || err_o[b] !== 1'b0) begin
        errors++;
        $display("FAIL after_reset[%0d]: stall=%b sc=%0h fc=%0h err=%b, required 0 0 0 0",
                 b, stall_o[b], sc_o[b], fc_o[b], err_o[b]);
      end
    end
  endtask

  initial begin
    @(posedge clock);
    #1;
    test_reset();
    test_load_use();
    test_cb_run();
    test_xzr();
    test_flush();
    test_random();
    test_watchdog_and_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
